// File: rtl/msk_pkg.sv
// Shared helpers for the masked datapath. Share i of a d*W bus sits at bits [i*W +: W];
// share 0 is the share that carries any lane inversion.
package msk_pkg;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 8;

  function automatic int share_lsb(input int i, input int w);
    return i * w;
  endfunction

  function automatic bit lat_in_range(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/msk_pipe_stage.sv
// One valid/ready register stage of the masked pipeline. Each share has its own register
// so the shares are never combined in one flop group.
module msk_pipe_stage
  import msk_pkg::*;
#(
  parameter int d = 2,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           ld,
  input  logic           prv_vld,
  input  logic [d*W-1:0] prv_sh,
  output logic           vld,
  output logic [d*W-1:0] sh
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vld <= 1'b0;
    else if (clr)
      vld <= 1'b0;
    else if (ld)
      vld <= prv_vld;
  end

  for (genvar i = 0; i < d; i++) begin : g_share
    logic [W-1:0] sh_r;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        sh_r <= '0;
      else if (clr)
        sh_r <= '0;
      else if (ld && prv_vld)
        sh_r <= prv_sh[share_lsb(i, W) +: W];
    end

    assign sh[share_lsb(i, W) +: W] = sh_r;
  end

endmodule

// File: rtl/msk_not_pipe.sv
// Masked bitwise-NOT: complements selected lanes of share 0 and carries all shares through
// a LAT-deep valid/ready pipeline. Optional flush port enabled by MSK_NOT_PIPE_FLUSH_EN.
module msk_not_pipe
  import msk_pkg::*;
#(
  parameter int d   = 2,
  parameter int W   = 8,
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef MSK_NOT_PIPE_FLUSH_EN
  input  logic           flush,
`endif
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [d*W-1:0] in_sh,
  input  logic [W-1:0]   in_inv,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [d*W-1:0] out_sh
);

  if (!lat_in_range(LAT) || (d < 2)) begin : g_bad_cfg
    $error("msk_not_pipe: LAT must be within 1..8 and d must be at least 2");
  end

  logic clr;
`ifdef MSK_NOT_PIPE_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  // Stage-0 input: inversion touches share 0 only, upper shares pass untouched
  logic [d*W-1:0] sh_p0;
  assign sh_p0 = {in_sh[d*W-1:W], in_sh[W-1:0] ^ in_inv};

  logic [LAT-1:0] vld_p;
  logic [d*W-1:0] sh_p [LAT];

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    logic           ld;
    logic           prv_vld;
    logic [d*W-1:0] prv_sh;

    // A stage may load when any stage from here to the output is empty, or the sink takes a beat
    assign ld = out_ready | ~(&vld_p[LAT-1:k]);

    if (k == 0) begin : g_head
      assign prv_vld = in_valid;
      assign prv_sh  = sh_p0;
    end else begin : g_body
      assign prv_vld = vld_p[k-1];
      assign prv_sh  = sh_p[k-1];
    end

    msk_pipe_stage #(
      .d (d),
      .W (W)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .ld      (ld),
      .prv_vld (prv_vld),
      .prv_sh  (prv_sh),
      .vld     (vld_p[k]),
      .sh      (sh_p[k])
    );
  end

  assign in_ready  = (out_ready | ~(&vld_p)) & ~clr;
  assign out_valid = vld_p[LAT-1];
  assign out_sh    = sh_p[LAT-1];

endmodule

// File: tb/tb_msk_not_pipe.sv
// Randomized bench for msk_not_pipe: two configurations checked against queue-based models.
module tb_msk_not_pipe;

  localparam int A_D = 2, A_W = 4, A_L = 2;
  localparam int B_D = 3, B_W = 8, B_L = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [A_D*A_W-1:0]   a_in_sh, a_out_sh;
  logic [A_W-1:0]       a_in_inv;
  logic                 b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [B_D*B_W-1:0]   b_in_sh, b_out_sh;
  logic [B_W-1:0]       b_in_inv;
`ifdef MSK_NOT_PIPE_FLUSH_EN
  logic flush = 1'b0;
`endif

  msk_not_pipe #(.d(A_D), .W(A_W), .LAT(A_L)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
`ifdef MSK_NOT_PIPE_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sh(a_in_sh), .in_inv(a_in_inv),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sh(a_out_sh)
  );

  msk_not_pipe #(.d(B_D), .W(B_W), .LAT(B_L)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
`ifdef MSK_NOT_PIPE_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sh(b_in_sh), .in_inv(b_in_inv),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sh(b_out_sh)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: FIFO of expected output beats, plus the expected unmasked value for config B
  logic [A_D*A_W-1:0] qa[$];
  logic [B_D*B_W-1:0] qb[$];
  logic [B_W-1:0]     qbx[$];
  bit a_hold = 0, b_hold = 0;
  bit gen = 0, inv_fix = 0;
  int rate_v = 100, rate_r = 100;
  logic [7:0] inv_val = 8'h00;

  task automatic step();
    bit a_acc, a_pop, b_acc, b_pop;
    @(negedge clk);
    a_out_ready = ($urandom_range(99) < rate_r);
    b_out_ready = ($urandom_range(99) < rate_r);
    if (!a_hold) begin
      a_in_valid = gen && ($urandom_range(99) < rate_v);
      a_in_sh    = 8'($urandom);
      a_in_inv   = inv_fix ? inv_val[3:0] : 4'($urandom);
    end
    if (!b_hold) begin
      b_in_valid = gen && ($urandom_range(99) < rate_v);
      b_in_sh    = 24'($urandom);
      b_in_inv   = inv_fix ? inv_val : 8'($urandom);
    end
    #1;
    // Ready whenever some stage is free or the sink drains this cycle
    chk("a_in_ready", a_in_ready, (qa.size() < A_L) || a_out_ready);
    chk("b_in_ready", b_in_ready, (qb.size() < B_L) || b_out_ready);
    if (a_out_valid) begin
      if (qa.size() == 0) chk("a_spurious_valid", a_out_valid, 1'b0);
      else chk("a_out_sh", a_out_sh, qa[0]);
    end
    if (b_out_valid) begin
      if (qb.size() == 0) chk("b_spurious_valid", b_out_valid, 1'b0);
      else begin
        chk("b_out_sh", b_out_sh, qb[0]);
        chk("b_unmasked", b_out_sh[7:0] ^ b_out_sh[15:8] ^ b_out_sh[23:16], qbx[0]);
      end
    end
    a_acc = a_in_valid && a_in_ready;
    b_acc = b_in_valid && b_in_ready;
    a_pop = a_out_valid && a_out_ready;
    b_pop = b_out_valid && b_out_ready;
    if (a_pop && qa.size() != 0) void'(qa.pop_front());
    if (b_pop && qb.size() != 0) begin
      void'(qb.pop_front());
      void'(qbx.pop_front());
    end
    if (a_acc) qa.push_back({a_in_sh[7:4], a_in_sh[3:0] ^ a_in_inv});
    if (b_acc) begin
      qb.push_back({b_in_sh[23:8], b_in_sh[7:0] ^ b_in_inv});
      qbx.push_back(b_in_sh[7:0] ^ b_in_sh[15:8] ^ b_in_sh[23:16] ^ b_in_inv);
    end
    a_hold = a_in_valid && !a_acc;
    b_hold = b_in_valid && !b_acc;
  endtask

  task automatic drain();
    gen = 0;
    rate_r = 100;
    for (int i = 0; i < 40 && (qa.size() != 0 || qb.size() != 0 || a_hold || b_hold); i++)
      step();
    chk("drain_a_left", qa.size(), 0);
    chk("drain_b_left", qb.size(), 0);
    step();
    step();
  endtask

  task automatic clear_model();
    qa.delete();
    qb.delete();
    qbx.delete();
    a_hold = 0;
    b_hold = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    a_in_valid = 0; a_in_sh = '0; a_in_inv = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_sh = '0; b_in_inv = '0; b_out_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_out_valid", a_out_valid, 1'b0);
    chk("rst_a_out_sh", a_out_sh, 8'h00);
    chk("rst_a_in_ready", a_in_ready, 1'b1);
    chk("rst_b_out_valid", b_out_valid, 1'b0);
    chk("rst_b_out_sh", b_out_sh, 24'h0);
    chk("rst_b_in_ready", b_in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single beat s0=3, s1=A, inv=F through the LAT=2 instance
    @(negedge clk);
    a_in_valid = 1; a_in_sh = 8'hA3; a_in_inv = 4'hF;
    @(negedge clk);
    a_in_valid = 0;
    #1 chk("lat_a_early", a_out_valid, 1'b0);
    @(negedge clk);
    #1;
    chk("lat_a_valid", a_out_valid, 1'b1);
    chk("lat_a_sh", a_out_sh, 8'hAC);
    chk("lat_a_unmasked", a_out_sh[7:4] ^ a_out_sh[3:0], 4'h6);
    @(negedge clk);
    #1 chk("lat_a_single", a_out_valid, 1'b0);

    // Back-to-back streaming, no inversion
    inv_fix = 1; inv_val = 8'h00; gen = 1; rate_v = 100; rate_r = 100;
    repeat (8) step();
    drain();

    // Stall with a full pipeline, then release; inversion of low nibble
    inv_val = 8'h0F; gen = 1; rate_v = 100; rate_r = 0;
    repeat (8) step();
    drain();

    // Random traffic with random masks and backpressure
    inv_fix = 0; gen = 1; rate_v = 60; rate_r = 60;
    repeat (300) step();
    drain();

    // Asynchronous reset with beats in flight
    gen = 1; rate_v = 100; rate_r = 0;
    repeat (2) step();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_a_valid", a_out_valid, 1'b0);
    chk("mid_rst_a_sh", a_out_sh, 8'h00);
    chk("mid_rst_b_valid", b_out_valid, 1'b0);
    chk("mid_rst_b_sh", b_out_sh, 24'h0);
    chk("mid_rst_b_ready", b_in_ready, 1'b1);
    a_in_valid = 0; b_in_valid = 0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    gen = 0; rate_r = 100;
    repeat (5) step();

`ifdef MSK_NOT_PIPE_FLUSH_EN
    gen = 1; rate_v = 100; rate_r = 0;
    repeat (2) step();
    @(negedge clk);
    flush = 1; a_in_valid = 1; b_in_valid = 1;
    #1;
    chk("flush_a_ready", a_in_ready, 1'b0);
    chk("flush_b_ready", b_in_ready, 1'b0);
    @(negedge clk);
    flush = 0; a_in_valid = 0; b_in_valid = 0; a_out_ready = 1; b_out_ready = 1;
    #1;
    chk("flush_a_valid", a_out_valid, 1'b0);
    chk("flush_b_valid", b_out_valid, 1'b0);
    clear_model();
    gen = 0; rate_r = 100;
    repeat (5) step();
`endif

    // Final randomized burst after reset recovery
    gen = 1; rate_v = 80; rate_r = 70;
    repeat (100) step();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
